// File: rtl/muldiv_unit_if.sv
// Request/response bundle between decode and the multiply/divide unit.
// master = decode side, slave = muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             op_err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val, cancel, hi_we, lo_we, wdata,
                  input  busy, done, div_zero, op_err, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, cancel, hi_we, lo_we, wdata,
                  output busy, done, div_zero, op_err, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO; radix-2, one bit per cycle.
// Divider is built only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU report op_err.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p;
  logic               neg_res, dz, err;
  logic               done_q, dz_q, err_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               rs_neg, rt_neg, accept, short_op, fin, wr_res;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, fix_res;

  assign rs_neg = bus.op[0] & bus.rs_val[WIDTH-1];
  assign rt_neg = bus.op[0] & bus.rt_val[WIDTH-1];
  assign rs_abs = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_abs = rt_neg ? -bus.rt_val : bus.rt_val;
  assign accept = (state == IDLE) && bus.start && !bus.cancel;

  // p = {partial product, remaining multiplier bits}; shifted right each cycle
  assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_reg} : '0);
  assign mul_nx  = {mul_sum, p[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic               is_div, neg_rem;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] div_nx;

  // p = {remainder, dividend bits shifting out / quotient bits shifting in}
  assign rem_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, a_reg};
  assign div_nx   = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign quo_fix  = neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign fix_res  = is_div ? {rem_fix, quo_fix} : (neg_res ? -p : p);
  assign short_op = bus.op[1] && (bus.rt_val == '0);
`else
  assign fix_res  = neg_res ? -p : p;
  assign short_op = bus.op[1];
`endif

  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = short_op ? FIX : RUN;
      RUN: begin
        if (bus.cancel)                    state_nx = IDLE;
        else if (count == CW'(WIDTH - 1))  state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
        fin      = !bus.cancel;
      end
      default: state_nx = IDLE;
    endcase
    wr_res = fin && !dz && !err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      a_reg   <= '0;
      p       <= '0;
      neg_res <= 1'b0;
      dz      <= 1'b0;
      err     <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      done_q <= fin;
      dz_q   <= fin & dz;
      err_q  <= fin & err;
      if (accept) begin
        count   <= '0;
        neg_res <= rs_neg ^ rt_neg;
        a_reg   <= bus.op[1] ? rt_abs : rs_abs;
        p       <= {{WIDTH{1'b0}}, bus.op[1] ? rs_abs : rt_abs};
`ifdef MULDIV_DIV_EN
        is_div  <= bus.op[1];
        neg_rem <= rs_neg;
        dz      <= short_op;
        err     <= 1'b0;
`else
        dz      <= 1'b0;
        err     <= short_op;
`endif
      end else if (state == RUN) begin
        count <= count + 1'b1;
`ifdef MULDIV_DIV_EN
        p     <= is_div ? div_nx : mul_nx;
`else
        p     <= mul_nx;
`endif
      end
      if (wr_res) begin
        hi_q <= fix_res[2*WIDTH-1:WIDTH];
        lo_q <= fix_res[WIDTH-1:0];
      end else if (state == IDLE && !bus.start) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.op_err   = err_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expected completions go to a queue checked by a done monitor.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit track, input int lat, input logic [31:0] eh,
                       input logic [31:0] el, input logic dz, input logic err);
    exp_t e;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    if (track) begin
      e.hi = eh; e.lo = el; e.dz = dz; e.err = err; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    tick();
    bus.start = 1'b0;
  endtask

  // ends in the done cycle of the operation
  task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input int lat, input logic [31:0] eh, input logic [31:0] el,
                       input logic dz, input logic err);
    issue(op, rs, rt, 1'b1, lat, eh, el, dz, err);
    chk("busy_first", 32'(bus.busy), 32'd1);
    run(lat - 2);
    chk("busy_last", 32'(bus.busy), 32'd1);
    run(1);
    cur_hi = eh;
    cur_lo = el;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        me = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(me.cyc));
        chk("done_hi", bus.hi, me.hi);
        chk("done_lo", bus.lo, me.lo);
        chk("done_div_zero", 32'(bus.div_zero), 32'(me.dz));
        chk("done_op_err", 32'(bus.op_err), 32'(me.err));
        chk("done_busy", 32'(bus.busy), 32'd0);
      end
    end else if (rst_n && (bus.div_zero !== 1'b0 || bus.op_err !== 1'b0)) begin
      checks++;
      errors++;
      $display("FAIL flag_without_done actual=%b%b expected=00 (cycle %0d)",
               bus.div_zero, bus.op_err, cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    chk("rst_err", 32'(bus.op_err), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // multiplies
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 34, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);

    // divides
`ifdef MULDIV_DIV_EN
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
`else
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 2, cur_hi, cur_lo, 1'b0, 1'b1);
    do_op(2'b10, 32'd100, 32'd7, 2, cur_hi, cur_lo, 1'b0, 1'b1);
`endif

    // MTHI/MTLO, both strobes then HI alone
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("mt_both_hi", bus.hi, 32'hA5A5_A5A5);
    chk("mt_both_lo", bus.lo, 32'hA5A5_A5A5);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_lo", bus.lo, 32'hA5A5_A5A5);
    cur_hi = 32'h0000_1234;
    cur_lo = 32'hA5A5_A5A5;

    // divide by zero: short path, HI/LO untouched
`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'd100, 32'd0, 2, cur_hi, cur_lo, 1'b1, 1'b0);
`else
    do_op(2'b10, 32'd100, 32'd0, 2, cur_hi, cur_lo, 1'b0, 1'b1);
`endif

    // start and MTHI while busy are ignored
    issue(2'b01, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 1'b0);
    run(4);
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd1; bus.rt_val = 32'd1;
    tick();
    bus.start = 1'b0;
    run(4);
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.hi_we = 1'b0;
    chk("busy_mthi_ignored", bus.hi, cur_hi);
    run(23);
    cur_hi = 32'hFFFF_FFFF;
    cur_lo = 32'hFFFF_FFF2;
    tick();
    chk("idle_after_stall", 32'(bus.busy), 32'd0);

    // cancel in cycle 10
    issue(2'b00, 32'd3, 32'd3, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    run(9);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", 32'(bus.busy), 32'd0);
    chk("cancel_hi", bus.hi, cur_hi);
    chk("cancel_lo", bus.lo, cur_lo);
    run(40);

    // cancel together with start in IDLE drops the start
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    tick();
    bus.cancel = 1'b0; bus.start = 1'b0;
    chk("cancel_start_busy", 32'(bus.busy), 32'd0);
    do_op(2'b00, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b0, 1'b0);

    // reset in cycle 20 of an operation
`ifdef MULDIV_DIV_EN
    issue(2'b11, 32'd1000, 32'd3, 1'b0, 0, '0, '0, 1'b0, 1'b0);
`else
    issue(2'b01, 32'd1000, 32'd3, 1'b0, 0, '0, '0, 1'b0, 1'b0);
`endif
    run(19);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    tick();
    do_op(2'b00, 32'd3, 32'd5, 34, 32'd0, 32'd15, 1'b0, 1'b0);

    run(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative MIPS multiply/divide unit with its own HI/LO register pair. It sits directly downstream of the register file: it consumes the two read-port values (rs, rt) for MULT/MULTU/DIV/DIVU and holds the 64-bit result in HI/LO. The decode stage reads HI/LO and routes them back to register-file writes for MFHI/MFLO. It also accepts MTHI/MTLO writes and reports busy so decode can stall dependent instructions.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request an operation; sampled only when busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- rs_val  in  32  multiplicand or dividend (register-file read port 1)
- rt_val  in  32  multiplier or divisor (register-file read port 2)
- cancel  in  1  abort the operation in flight
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- div_zero  out  1  divisor was zero; valid with done
- op_err  out  1  unsupported op; valid with done
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset state: IDLE. Reset values: busy=0, done=0, div_zero=0, op_err=0, hi=0, lo=0, count=0.
- States: IDLE, RUN, FIX.
- IDLE with start=1:
  - Latch op and operand signs.
  - Latch |rs_val| and |rt_val| for signed ops; latch raw values for unsigned ops.
  - Go to RUN with count=0.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, 32 cycles. Builds a 64-bit unsigned product.
- RUN, divide: restoring division, one quotient bit per cycle, 32 cycles. Builds a 32-bit quotient and remainder.
- FIX (one cycle), sign correction:
  - Product is negated if the operand signs differ (MULT only).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend (DIV only).
- Exit from FIX to IDLE:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - done=1 for exactly one cycle.
- Divide by zero (DIVU/DIV with rt_val=0):
  - Skip RUN; go IDLE→FIX→IDLE.
  - HI/LO unchanged; div_zero=1 with done.
- 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0. This falls out naturally from 32-bit wrap; no special case.
- MTHI/MTLO:
  - In IDLE with start=0, hi_we/lo_we load wdata into HI/LO at the next edge.
  - Both strobes may be asserted together.
  - Ignored while busy=1 or when start=1.
- start while busy=1: ignored, no side effects.
- cancel:
  - When busy=1: return to IDLE at the next edge. HI/LO unchanged, no done pulse.
  - When busy=0: no effect.
  - cancel and start in the same IDLE cycle: start is ignored.
- Reset mid-operation: outputs take their reset values immediately; the operation is lost.

## Timing
- start sampled high in cycle 0.
- Normal operation:
  - busy=1 in cycles 1–33 (RUN in cycles 1–32, FIX in cycle 33).
  - Cycle 34: done=1, busy=0, HI/LO hold the new result.
  - A new start is accepted in cycle 34.
- Divide by zero or unsupported op: busy=1 in cycle 1; done=1 and busy=0 in cycle 2.
- div_zero and op_err are high only in the done cycle; 0 otherwise.
- MTHI/MTLO write latency: value appears on hi/lo one cycle after the strobe.
- hi/lo are registered outputs with no combinational path from inputs.

## Configuration
- MULDIV_DIV_EN defined: DIVU/DIV are implemented as described above.
- MULDIV_DIV_EN undefined:
  - Divider datapath is removed.
  - op 10/11 completes in cycle 2 with op_err=1; HI/LO unchanged; div_zero stays 0.
  - Multiply behaviour is identical in both builds.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0x00000002 → done in cycle 34; HI=0x00000001, LO=0xFFFFFFFE. MULT with the same operands → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- MTHI 0x1234, then DIVU 100/0 → done and div_zero=1 in cycle 2; HI=0x1234, LO unchanged. Without MULDIV_DIV_EN the same DIVU → op_err=1, div_zero=0.
- Busy/stall handling:
  - start MULT, then assert start with new operands in cycle 5 → ignored; exactly one done, in cycle 34.
  - hi_we in cycle 10 → ignored.
- cancel in cycle 10 of a MULT → busy=0 in cycle 11; no done; HI/LO keep their prior values. The next start is accepted normally.
- rst_n low in cycle 20 of a DIV → busy, done, hi and lo are 0 immediately. After release, MULTU 3×5 → LO=15, HI=0.
